// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    // Odd parity over data+parity, and the stop bit must be high.
    function automatic logic ps2_frame_good(
        input logic [7:0] data_byte,
        input logic       par_bit,
        input logic       stop_bit
    );
        return (^{data_byte, par_bit}) & stop_bit;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length filter for one PS/2 line.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] run_cnt;

    // filt only follows the synchronised line after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            run_cnt <= '0;
            filt    <= 1'b1;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_LAST) begin
                filt    <= sync_q2;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device->host frame receiver with E0/F0 prefix folding into key events.
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a clk fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking parity and stop, then back to IDLE
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_strobe
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic            clk_f;
    logic            data_f;
    logic            clk_f_q;
    logic            fall;
    ps2_state_t      state;
    ps2_state_t      state_nxt;
    logic [7:0]      shreg;
    logic [2:0]      bitcnt;
    logic            par_bit;
    logic [WD_W-1:0] wdog;
    logic            frame_ok;
    logic            frame_err;
    logic            timeout_err;
    logic            ext_p;
    logic            rel_p;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (ps2_clk),
        .filt    (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (ps2_data),
        .filt    (data_f)
    );

    assign fall = clk_f_q & ~clk_f;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_f_q <= 1'b1;
            state   <= IDLE;
        end else begin
            clk_f_q <= clk_f;
            state   <= state_nxt;
        end
    end

    // A clk fall takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt   = state;
        frame_ok    = 1'b0;
        frame_err   = 1'b0;
        timeout_err = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_f) state_nxt = DATA;
                end
                DATA: begin
                    if (bitcnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (ps2_frame_good(shreg, par_bit, data_f)) frame_ok = 1'b1;
                    else frame_err = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && wdog == WD_LAST) begin
            state_nxt   = IDLE;
            timeout_err = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shreg   <= '0;
            bitcnt  <= '0;
            par_bit <= 1'b0;
        end else if (fall) begin
            case (state)
                IDLE: bitcnt <= '0;
                DATA: begin
                    shreg  <= {data_f, shreg[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                end
                PARITY:  par_bit <= data_f;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wdog <= '0;
        end else if (fall || state == IDLE) begin
            wdog <= '0;
        end else if (wdog != '1) begin
            wdog <= wdog + WD_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= frame_ok;
            rx_err   <= frame_err | timeout_err;
            if (frame_ok) rx_data <= shreg;
        end
    end

    // Prefix bytes only arm flags; any other byte becomes a key event carrying them.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ext_p       <= 1'b0;
            rel_p       <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_strobe  <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_err) begin
                ext_p <= 1'b0;
                rel_p <= 1'b0;
            end else if (rx_valid) begin
                if (rx_data == PS2_PFX_EXT) begin
                    ext_p <= 1'b1;
                end else if (rx_data == PS2_PFX_BRK) begin
                    rel_p <= 1'b1;
                end else begin
                    key_code    <= rx_data;
                    key_ext     <= ext_p;
                    key_release <= rel_p;
                    key_strobe  <= 1'b1;
                    ext_p       <= 1'b0;
                    rel_p       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx with a queue-based model of frames, prefixes and errors.
module tb_ps2_kbd_rx;

    localparam int FLEN = 8;
    localparam int TMO  = 300;
    localparam int HALF = 20;
    localparam int LAT  = FLEN + 3;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_t;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_strobe;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ref_cyc = 0;
    int         exp_err = 0;
    bit         exp_timeout = 1'b0;
    bit         m_ext = 1'b0;
    bit         m_rel = 1'b0;
    logic [7:0] exp_rx[$];
    key_t       exp_key[$];
    key_t       k;
    logic [7:0] held_rx = 8'h00;
    key_t       held_key = '0;
    logic       prev_valid = 1'b0;

    ps2_kbd_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_err      (rx_err),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_strobe  (key_strobe)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Model: what a complete frame must produce, decided before it is sent.
    task automatic expect_frame(input logic [7:0] b, input bit good);
        exp_timeout = 1'b0;
        if (good) begin
            exp_rx.push_back(b);
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
                exp_key.push_back('{code: b, ext: m_ext, rel: m_rel});
                m_ext = 1'b0;
                m_rel = 1'b0;
            end
        end else begin
            exp_err++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic expect_timeout();
        exp_timeout = 1'b1;
        exp_err++;
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        logic        par;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            ref_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic good_frame(input logic [7:0] b);
        expect_frame(b, 1'b1);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic chk_drained(input string name);
        chk(name, exp_rx.size() + exp_key.size() + exp_err, 0);
    endtask

    always @(negedge clk_sys) begin
        if (reset) begin
            held_rx    = 8'h00;
            held_key   = '0;
            prev_valid = 1'b0;
        end else begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) chk("rx_valid_unexpected", rx_valid, 0);
                else begin
                    held_rx = exp_rx.pop_front();
                    chk("rx_valid_latency", cyc - ref_cyc, LAT);
                end
            end
            if (rx_err) begin
                if (exp_err == 0) chk("rx_err_unexpected", rx_err, 0);
                else begin
                    exp_err--;
                    if (exp_timeout) chk("timeout_latency", cyc - ref_cyc, TMO + LAT);
                    else chk("rx_err_latency", cyc - ref_cyc, LAT);
                end
            end
            if (key_strobe) begin
                chk("strobe_follows_valid", prev_valid, 1);
                if (exp_key.size() == 0) chk("key_strobe_unexpected", key_strobe, 0);
                else held_key = exp_key.pop_front();
            end
            chk("rx_data", rx_data, held_rx);
            chk("key_fields", {key_code, key_ext, key_release}, held_key);
            prev_valid = rx_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        tick(5);
        chk("reset_outputs", {rx_data, rx_valid, rx_err, key_code, key_ext, key_release, key_strobe}, 0);
        reset = 1'b0;
        tick(30);

        // 1: plain make code
        good_frame(8'h1C);
        chk("t1_rx_data", rx_data, 8'h1C);
        chk("t1_key", {key_code, key_ext, key_release}, {8'h1C, 1'b0, 1'b0});
        chk_drained("t1_drained");

        // 2: break code, then make again
        good_frame(8'hF0);
        good_frame(8'h1C);
        chk("t2_break", {key_code, key_ext, key_release}, {8'h1C, 1'b0, 1'b1});
        good_frame(8'h1C);
        chk("t2_make", {key_code, key_ext, key_release}, {8'h1C, 1'b0, 1'b0});
        chk_drained("t2_drained");

        // 3: extended break, then flags must be clear
        good_frame(8'hE0);
        good_frame(8'hF0);
        good_frame(8'h75);
        chk("t3_ext_break", {key_code, key_ext, key_release}, {8'h75, 1'b1, 1'b1});
        good_frame(8'h1C);
        chk("t3_flags_clear", {key_code, key_ext, key_release}, {8'h1C, 1'b0, 1'b0});
        chk_drained("t3_drained");

        // 4: bad parity, bad stop, then a good frame
        expect_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0, 11);
        chk("t4_rx_data_held", rx_data, 8'h1C);
        expect_frame(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 11);
        good_frame(8'h32);
        chk("t4_recover", {rx_data, key_code, key_ext, key_release}, {8'h32, 8'h32, 1'b0, 1'b0});
        chk_drained("t4_drained");

        // 5: E0 then a stalled frame; timeout clears the pending prefix
        good_frame(8'hE0);
        expect_timeout();
        send_frame(8'h55, 1'b0, 1'b0, 5);
        tick(TMO + 40);
        chk_drained("t5_timeout_seen");
        good_frame(8'h29);
        chk("t5_ext_cleared", {key_code, key_ext, key_release}, {8'h29, 1'b0, 1'b0});
        chk_drained("t5_drained");

        // 6a: short clk glitch with data low in IDLE must not start a frame
        ps2_data = 1'b0;
        tick(3);
        ps2_clk = 1'b0;
        tick(5);
        ps2_clk = 1'b1;
        tick(3);
        ps2_data = 1'b1;
        tick(40);
        good_frame(8'h1B);
        chk("t6_after_glitch", {rx_data, key_code}, {8'h1B, 8'h1B});

        // 6b: pending E0, reset mid-frame, then a clean frame
        good_frame(8'hE0);
        send_frame(8'hAA, 1'b0, 1'b0, 4);
        reset = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("t6_reset_outputs", {rx_data, rx_err, key_code, key_ext, key_release}, 0);
        tick(20);
        good_frame(8'h1C);
        chk("t6_after_reset", {rx_data, key_code, key_ext, key_release}, {8'h1C, 8'h1C, 1'b0, 1'b0});
        tick(TMO + 20);
        chk_drained("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
